sa_ram_rdctl_16x14: RTL and testbench

SA_RAM_RDCTL_16X14 -- requirements
Module: sa_ram_rdctl_16x14

---
 rtl/sa_ram_rdctl_16x14.sv | 90 +++++++++
 tb/tb_sa_ram_rdctl_16x14.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_ram_rdctl_16x14.sv
// Read/write controller for a 16x14 RAM with a registered output stage.
// Optional synchronous flush port enabled by defining SA_RAM_RDCTL_FLUSH_EN.
module sa_ram_rdctl_16x14 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_pvld,
  output logic        wr_prdy,
  input  logic [13:0] wr_pd,
  output logic        rd_pvld,
  input  logic        rd_prdy,
  output logic [13:0] rd_pd,
  output logic [4:0]  rd_count,
  output logic [3:0]  ram_wa,
  output logic        ram_we,
  output logic [13:0] ram_di,
  output logic [3:0]  ram_ra,
  output logic        ram_re,
  output logic        ram_ore,
  input  logic [13:0] ram_dout
`ifdef SA_RAM_RDCTL_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  logic [3:0] wp;
  logic [3:0] rp;
  logic       s1;
  logic       s2;
  logic [4:0] occ;
  logic [4:0] unread;
  logic [5:0] held;
  logic       kill;

`ifdef SA_RAM_RDCTL_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  // occ still counts the word whose address sits in stage 1, so the
  // entries not yet addressed are occ minus that one.
  assign unread   = occ - {4'd0, s1};

  assign wr_prdy  = (occ != 5'd16);
  assign ram_we   = wr_pvld & wr_prdy & ~kill;
  assign ram_wa   = wp;
  assign ram_di   = wr_pd;

  assign ram_ore  = s1 & (~s2 | rd_prdy) & ~kill;
  assign ram_re   = (unread != 5'd0) & (~s1 | ram_ore) & ~kill;
  assign ram_ra   = rp;

  assign rd_pvld  = s2;
  assign rd_pd    = ram_dout;

  // The output register adds a 17th slot, so the sum can exceed 16.
  assign held     = {1'b0, occ} + {5'd0, s2};
  assign rd_count = (held > 6'd16) ? 5'd16 : held[4:0];

  // NOTE: all state uses non-blocking assignments so every update in this
  // block sees the pre-edge values, matching the combinational strobes above.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp  <= 4'd0;
      rp  <= 4'd0;
      s1  <= 1'b0;
      s2  <= 1'b0;
      occ <= 5'd0;
    end else if (kill) begin
      wp  <= 4'd0;
      rp  <= 4'd0;
      s1  <= 1'b0;
      s2  <= 1'b0;
      occ <= 5'd0;
    end else begin
      if (ram_we) wp <= wp + 4'd1;
      if (ram_re) rp <= rp + 4'd1;
      s1 <= ram_re | (s1 & ~ram_ore);
      s2 <= ram_ore | (s2 & ~rd_prdy);
      // An entry is released only when its data reaches the output register.
      case ({ram_we, ram_ore})
        2'b10:   occ <= occ + 5'd1;
        2'b01:   occ <= occ - 5'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_ram_rdctl_16x14.sv
// Directed bench for sa_ram_rdctl_16x14 with a behavioural 16x14 RAM model.
// Flush scenario runs only when SA_RAM_RDCTL_FLUSH_EN is defined.
module tb_sa_ram_rdctl_16x14;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_pvld = 1'b0;
  logic        wr_prdy;
  logic [13:0] wr_pd = 14'd0;
  logic        rd_pvld;
  logic        rd_prdy = 1'b0;
  logic [13:0] rd_pd;
  logic [4:0]  rd_count;
  logic [3:0]  ram_wa;
  logic        ram_we;
  logic [13:0] ram_di;
  logic [3:0]  ram_ra;
  logic        ram_re;
  logic        ram_ore;
  logic [13:0] ram_dout;
`ifdef SA_RAM_RDCTL_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int hazards = 0;

  sa_ram_rdctl_16x14 dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_pvld  (wr_pvld),
    .wr_prdy  (wr_prdy),
    .wr_pd    (wr_pd),
    .rd_pvld  (rd_pvld),
    .rd_prdy  (rd_prdy),
    .rd_pd    (rd_pd),
    .rd_count (rd_count),
    .ram_wa   (ram_wa),
    .ram_we   (ram_we),
    .ram_di   (ram_di),
    .ram_ra   (ram_ra),
    .ram_re   (ram_re),
    .ram_ore  (ram_ore),
    .ram_dout (ram_dout)
`ifdef SA_RAM_RDCTL_FLUSH_EN
    ,
    .flush    (flush)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: registered write, address captured on re, data on ore.
  logic [13:0] mem [16];
  logic [3:0]  ra_q = 4'd0;
  logic [13:0] dout_q = 14'd0;
  assign ram_dout = dout_q;

  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_q <= ram_ra;
    if (ram_ore) dout_q <= mem[ra_q];
  end

  // Track the address held between re and ore; any write to it is a hazard.
  logic       pend = 1'b0;
  logic [3:0] pend_a = 4'd0;
  logic       flush_now;
`ifdef SA_RAM_RDCTL_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= 1'b0;
    end else begin
      if (ram_we && pend && ram_wa == pend_a) hazards <= hazards + 1;
      if (flush_now)    pend <= 1'b0;
      else if (ram_re) begin
        pend   <= 1'b1;
        pend_a <= ram_ra;
      end else if (ram_ore) pend <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (wr_prdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_wr_prdy got %b exp 1", wr_prdy);
    end
    n_tests++;
    if (rd_pvld !== 1'b0) begin
      n_fail++; $display("FAIL reset_rd_pvld got %b exp 0", rd_pvld);
    end
    n_tests++;
    if (rd_count !== 5'd0) begin
      n_fail++; $display("FAIL reset_rd_count got %0d exp 0", rd_count);
    end
    n_tests++;
    if ({ram_we, ram_re, ram_ore} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes got %b exp 000", {ram_we, ram_re, ram_ore});
    end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    wr_pvld = 1'b1; wr_pd = 14'h0001; rd_prdy = 1'b1;
    #1;
    n_tests++;
    if ({ram_we, ram_wa, ram_di, ram_re} !== {1'b1, 4'd0, 14'h0001, 1'b0}) begin
      n_fail++; $display("FAIL lat_c0 got we=%b wa=%h di=%h re=%b exp 1 0 0001 0",
                         ram_we, ram_wa, ram_di, ram_re);
    end
    tick();
    wr_pvld = 1'b0;
    #1;
    n_tests++;
    if ({ram_re, ram_ra, ram_ore, rd_pvld} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL lat_c1 got re=%b ra=%h ore=%b vld=%b exp 1 0 0 0",
                         ram_re, ram_ra, ram_ore, rd_pvld);
    end
    tick();
    n_tests++;
    if ({ram_ore, ram_re, rd_pvld} !== 3'b100) begin
      n_fail++; $display("FAIL lat_c2 got ore=%b re=%b vld=%b exp 1 0 0", ram_ore, ram_re, rd_pvld);
    end
    tick();
    n_tests++;
    if ({rd_pvld, rd_pd, rd_count} !== {1'b1, 14'h0001, 5'd1}) begin
      n_fail++; $display("FAIL lat_c3 got vld=%b pd=%h cnt=%0d exp 1 0001 1", rd_pvld, rd_pd, rd_count);
    end
    tick();
    n_tests++;
    if ({rd_pvld, ram_re, rd_count} !== {1'b0, 1'b0, 5'd0}) begin
      n_fail++; $display("FAIL lat_empty got vld=%b re=%b cnt=%0d exp 0 0 0", rd_pvld, ram_re, rd_count);
    end
  endtask

  // Fills the block while stalled (17 words fit: 16 in RAM plus the output
  // register), checks the stall and full-write cases, then drains in order.
  task automatic test_fill_and_stall();
    rd_prdy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_pvld = 1'b1; wr_pd = 14'(i);
      #1;
      n_tests++;
      if (ram_we !== 1'b1) begin
        n_fail++; $display("FAIL fill_we[%0d] got %b exp 1", i, ram_we);
      end
      tick();
    end
    wr_pd = 14'h1234;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++;
      if ({wr_prdy, ram_we, ram_ore, rd_count} !== {1'b0, 1'b0, 1'b0, 5'd16}) begin
        n_fail++; $display("FAIL full_stall[%0d] got prdy=%b we=%b ore=%b cnt=%0d exp 0 0 0 16",
                           c, wr_prdy, ram_we, ram_ore, rd_count);
      end
      n_tests++;
      if ({rd_pvld, rd_pd} !== {1'b1, 14'h0000}) begin
        n_fail++; $display("FAIL stall_pd[%0d] got vld=%b pd=%h exp 1 0000", c, rd_pvld, rd_pd);
      end
      tick();
    end
    rd_prdy = 1'b1;
    #1;
    n_tests++;
    if ({ram_ore, wr_prdy, ram_we} !== 3'b100) begin
      n_fail++; $display("FAIL full_ore_wr got ore=%b prdy=%b we=%b exp 1 0 0", ram_ore, wr_prdy, ram_we);
    end
    tick();
    wr_pvld = 1'b0;
    #1;
    n_tests++;
    if (rd_count !== 5'd16) begin
      n_fail++; $display("FAIL full_after_ore cnt got %0d exp 16", rd_count);
    end
    for (int k = 1; k < 17; k++) begin
      n_tests++;
      if ({rd_pvld, rd_pd} !== {1'b1, 14'(k)}) begin
        n_fail++; $display("FAIL drain[%0d] got vld=%b pd=%h exp 1 %h", k, rd_pvld, rd_pd, 14'(k));
      end
      tick();
    end
    n_tests++;
    if ({rd_pvld, rd_count} !== {1'b0, 5'd0}) begin
      n_fail++; $display("FAIL drain_empty got vld=%b cnt=%0d exp 0 0", rd_pvld, rd_count);
    end
    n_tests++;
    if (hazards !== 0) begin
      n_fail++; $display("FAIL no_overwrite got %0d exp 0", hazards);
    end
  endtask

  task automatic test_back_to_back();
    rd_prdy = 1'b1;
    for (int t = 0; t < 45; t++) begin
      wr_pvld = (t < 40);
      wr_pd   = 14'(14'h100 + t);
      #1;
      if (t < 40) begin
        n_tests++;
        if ({wr_prdy, ram_we} !== 2'b11) begin
          n_fail++; $display("FAIL stream_wr[%0d] got prdy=%b we=%b exp 1 1", t, wr_prdy, ram_we);
        end
      end
      if (t >= 3 && t < 43) begin
        n_tests++;
        if ({rd_pvld, rd_pd} !== {1'b1, 14'(14'h100 + t - 3)}) begin
          n_fail++; $display("FAIL stream_rd[%0d] got vld=%b pd=%h exp 1 %h",
                             t, rd_pvld, rd_pd, 14'(14'h100 + t - 3));
        end
      end
      tick();
    end
    n_tests++;
    if ({rd_pvld, rd_count} !== {1'b0, 5'd0}) begin
      n_fail++; $display("FAIL stream_empty got vld=%b cnt=%0d exp 0 0", rd_pvld, rd_count);
    end
  endtask

  task automatic load_five();
    rd_prdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_pvld = 1'b1; wr_pd = 14'(14'h200 + i);
      tick();
    end
    wr_pvld = 1'b0;
    #1;
    n_tests++;
    if (rd_count !== 5'd5) begin
      n_fail++; $display("FAIL load5_cnt got %0d exp 5", rd_count);
    end
  endtask

  task automatic test_reset_mid();
    load_five();
    #1;
    rstn = 1'b0;
    #1;
    n_tests++;
    if ({rd_count, rd_pvld, wr_prdy} !== {5'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL async_rst got cnt=%0d vld=%b prdy=%b exp 0 0 1", rd_count, rd_pvld, wr_prdy);
    end
    tick();
    rstn = 1'b1;
    rd_prdy = 1'b1;
    tick();
    n_tests++;
    if ({rd_pvld, ram_re, ram_ore} !== 3'b000) begin
      n_fail++; $display("FAIL rst_after got vld=%b re=%b ore=%b exp 0 0 0", rd_pvld, ram_re, ram_ore);
    end
  endtask

`ifdef SA_RAM_RDCTL_FLUSH_EN
  task automatic test_flush();
    load_five();
    flush = 1'b1; wr_pvld = 1'b1; wr_pd = 14'h3FFF; rd_prdy = 1'b1;
    #1;
    n_tests++;
    if ({ram_we, ram_re, ram_ore} !== 3'b000) begin
      n_fail++; $display("FAIL flush_gate got we=%b re=%b ore=%b exp 0 0 0", ram_we, ram_re, ram_ore);
    end
    tick();
    flush = 1'b0; wr_pvld = 1'b0;
    #1;
    n_tests++;
    if ({rd_count, rd_pvld, wr_prdy} !== {5'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL flush_after got cnt=%0d vld=%b prdy=%b exp 0 0 1", rd_count, rd_pvld, wr_prdy);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_fill_and_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef SA_RAM_RDCTL_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
